// File: rtl/comp_pkg.sv
// Shared types and constants for the registered magnitude comparator.
package comp_pkg;

  // Default operand width for comparator instances.
  localparam int DEFAULT_WIDTH = 4;

  // One-hot compare result; all-zero only before the first capture.
  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_res_t;

  localparam cmp_res_t CMP_GT   = '{gt: 1'b1, lt: 1'b0, eq: 1'b0};
  localparam cmp_res_t CMP_LT   = '{gt: 1'b0, lt: 1'b1, eq: 1'b0};
  localparam cmp_res_t CMP_EQ   = '{gt: 1'b0, lt: 1'b0, eq: 1'b1};
  localparam cmp_res_t CMP_NONE = '{gt: 1'b0, lt: 1'b0, eq: 1'b0};

endpackage : comp_pkg

// File: rtl/comp_1bit.sv
// One slice of an MSB-first magnitude compare cascade. Once an upstream
// slice has decided gt or lt, the decision passes straight through;
// otherwise the local bit pair decides, and equal bits keep eq alive.
module comp_1bit (
  input  logic a,
  input  logic b,
  input  logic gt_in,
  input  logic lt_in,
  input  logic eq_in,
  output logic gt_out,
  output logic lt_out,
  output logic eq_out
);

  // Pass an upstream decision through, else resolve from this bit pair.
  always_comb begin
    gt_out = gt_in;
    lt_out = lt_in;
    eq_out = eq_in;
    if (!gt_in && !lt_in) begin
      if (a != b) begin
        gt_out = a;
        lt_out = b;
        eq_out = 1'b0;
      end
    end
  end

endmodule : comp_1bit

// File: rtl/comp_4_bit.sv
// Registered unsigned magnitude comparator built from a chain of 1-bit
// slices, MSB first, followed by a single output register stage.
//
// Handshake: no ready signal and no backpressure. Operands are taken on
// every rising edge where in_valid=1; out_valid is high for exactly the
// cycle after each capture. While in_valid=0, out_valid drops and
// gt/lt/eq hold the last captured result.
module comp_4_bit
  import comp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  // Cascade nets: index WIDTH is the seed, index 0 is the final result.
  logic [WIDTH:0] gt_c;
  logic [WIDTH:0] lt_c;
  logic [WIDTH:0] eq_c;

  cmp_res_t res_q;
  logic     valid_q;

  // Nothing decided yet at the MSB: start out equal.
  assign gt_c[WIDTH] = 1'b0;
  assign lt_c[WIDTH] = 1'b0;
  assign eq_c[WIDTH] = 1'b1;

  for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_slice
    comp_1bit u_slice (
      .a      (a[i]),
      .b      (b[i]),
      .gt_in  (gt_c[i+1]),
      .lt_in  (lt_c[i+1]),
      .eq_in  (eq_c[i+1]),
      .gt_out (gt_c[i]),
      .lt_out (lt_c[i]),
      .eq_out (eq_c[i])
    );
  end

  // Capture the cascade result on valid input; hold it through idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      res_q   <= CMP_NONE;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        res_q <= '{gt: gt_c[0], lt: lt_c[0], eq: eq_c[0]};
      end
    end
  end

  assign out_valid = valid_q;
  assign gt        = res_q.gt;
  assign lt        = res_q.lt;
  assign eq        = res_q.eq;

endmodule : comp_4_bit

// File: tb/tb_comp_4_bit.sv
// Self-checking bench for comp_4_bit: a behavioural model computes results
// with plain integer comparison, and a scoreboard queue pairs every
// captured operand pair with the out_valid cycle that reports it.
module tb_comp_4_bit;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         gt;
  logic         lt;
  logic         eq;

  always #5 clk = ~clk;

  comp_4_bit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .gt        (gt),
    .lt        (lt),
    .eq        (eq)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  function automatic void check(string name, logic [31:0] actual, logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // Expected {gt,lt,eq} per capture, oldest first.
  logic [2:0] exp_q[$];
  logic       exp_valid = 1'b0;
  logic [2:0] exp_hold  = 3'b000;

  function automatic logic [2:0] model_cmp(int unsigned x, int unsigned y);
    return {x > y, x < y, x == y};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_valid = 1'b0;
      exp_hold  = 3'b000;
      exp_q.delete();
    end else begin
      exp_valid = in_valid;
      if (in_valid) begin
        exp_hold = model_cmp(int'(a), int'(b));
        exp_q.push_back(exp_hold);
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      check("held_result", 32'({gt, lt, eq}), 32'(exp_hold));
      if (out_valid) begin
        check("onehot", 32'($countones({gt, lt, eq})), 32'd1);
        if (exp_q.size() == 0) begin
          check("sb_unexpected_valid", 32'd1, 32'd0);
        end else begin
          check("sb_result", 32'({gt, lt, eq}), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic v);
    @(posedge clk);
    #1;
    a        = aa;
    b        = bb;
    in_valid = v;
  endtask

  task automatic idle();
    drive('0, '0, 1'b0);
  endtask

  // Drive one vector, then look at the outputs right after its capture edge.
  task automatic directed(input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic [2:0] want, input string name);
    drive(aa, bb, 1'b1);
    idle();
    check(name, 32'({out_valid, gt, lt, eq}), 32'({1'b1, want}));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_values", 32'({out_valid, gt, lt, eq}), 32'h0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Directed vectors with hand-computed results.
    directed(4'd10, 4'd5,  3'b100, "dir_10_5");
    directed(4'd3,  4'd7,  3'b010, "dir_3_7");
    directed(4'd12, 4'd12, 3'b001, "dir_12_12");
    directed(4'd0,  4'd0,  3'b001, "dir_0_0");
    directed(4'd15, 4'd14, 3'b100, "dir_15_14");
    directed(4'd8,  4'd9,  3'b010, "dir_8_9");
    directed(4'd8,  4'd7,  3'b100, "msb_8_7");
    directed(4'd7,  4'd8,  3'b010, "msb_7_8");

    // Stream with a two-cycle gap.
    drive(4'd1, 4'd2, 1'b1);
    drive(4'd9, 4'd3, 1'b1);
    drive(4'd6, 4'd6, 1'b1);
    idle();
    check("gap_last_vec", 32'({out_valid, gt, lt, eq}), 32'b1001);
    idle();
    check("gap_hold_1", 32'({out_valid, gt, lt, eq}), 32'b0001);
    drive(4'd2, 4'd11, 1'b1);
    check("gap_hold_2", 32'({out_valid, gt, lt, eq}), 32'b0001);
    idle();
    check("after_gap", 32'({out_valid, gt, lt, eq}), 32'b1010);

    // Asynchronous reset between edges, with a result on the outputs.
    drive(4'd13, 4'd1, 1'b1);
    idle();
    #1;
    rst = 1'b1;
    #1;
    check("async_reset", 32'({out_valid, gt, lt, eq}), 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Mid-stream reset during back-to-back traffic.
    drive(4'd14, 4'd2, 1'b1);
    drive(4'd5,  4'd9, 1'b1);
    drive(4'd7,  4'd7, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("midstream_reset", 32'({out_valid, gt, lt, eq}), 32'h0);
    drive(4'd1, 4'd15, 1'b1);
    #1;
    rst = 1'b0;
    drive(4'd4, 4'd4, 1'b1);
    idle();
    check("post_reset_eq", 32'({out_valid, gt, lt, eq}), 32'b1001);

    // Exhaustive back-to-back sweep.
    for (int i = 0; i < 256; i++) begin
      drive(W'(i >> 4), W'(i & 15), 1'b1);
    end
    idle();
    idle();

    // Random operands with random valid gaps.
    for (int i = 0; i < 300; i++) begin
      drive(W'($urandom_range(15, 0)), W'($urandom_range(15, 0)),
            1'($urandom_range(1, 0)));
    end
    idle();
    idle();
    @(posedge clk);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_comp_4_bit
